// File: rtl/uvme_st_stream_chkr.sv
// ---------------------------------------------------------------------------
// uvme_st_stream_chkr
//   Multi-channel, in-order stream checker. Every accepted TX beat is queued
//   in a per-channel FIFO; every accepted RX beat on a channel is compared
//   against the oldest queued entry of that channel. Mismatch, orphan,
//   overflow and head-latency timeout events pulse for one cycle, and
//   saturating match/error counters are kept.
//
//   Optional feature macro: UVME_ST_CHKR_SVA_EN
//     defined   -> protocol / range / X concurrent assertions compiled in,
//                  plus an $error on every err_* pulse (all off in reset).
//     undefined -> no assertion code; outputs are identical.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   enable                : 1 = check beats and age heads; 0 = freeze
//   tx_valid/ready/chan/data : transmit stream (expected data source)
//   rx_valid/ready/chan/data : receive stream (data under check)
//   err_mismatch_o        : pulse, RX data differs from expected
//   err_orphan_o          : pulse, RX beat with nothing expected
//   err_overflow_o        : pulse, TX beat dropped because FIFO full
//   err_timeout_o         : pulse, one or more channel heads timed out
//   match_cnt_o           : saturating count of matched beats
//   err_cnt_o             : saturating count of error events
//   pending_o             : bit c set while channel c FIFO is non-empty
//   idle_o                : every FIFO empty
//
// Handshake: a beat is transferred on a rising clk edge where valid and
// ready are both 1 (and enable is 1). The source holds valid, chan and data
// stable until ready is seen; ready may change freely.
// ---------------------------------------------------------------------------
module uvme_st_stream_chkr #(
  parameter int DATA_W  = 32,
  parameter int NUM_CH  = 4,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              tx_valid,
  input  logic              tx_ready,
  input  logic [CH_W-1:0]   tx_chan,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              rx_valid,
  input  logic              rx_ready,
  input  logic [CH_W-1:0]   rx_chan,
  input  logic [DATA_W-1:0] rx_data,
  output logic              err_mismatch_o,
  output logic              err_orphan_o,
  output logic              err_overflow_o,
  output logic              err_timeout_o,
  output logic [CNT_W-1:0]  match_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic [NUM_CH-1:0] pending_o,
  output logic              idle_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam int AGE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int ADD_W = $clog2(NUM_CH + 4) + 1;
  localparam int SUM_W = ((CNT_W > ADD_W) ? CNT_W : ADD_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] mem    [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  rd_ptr [NUM_CH];
  logic [PTR_W-1:0]  wr_ptr [NUM_CH];
  logic [OCC_W-1:0]  occ    [NUM_CH];
  logic [AGE_W-1:0]  age    [NUM_CH];

  logic              tx_beat, rx_beat;
  logic [NUM_CH-1:0] tx_hit, rx_hit, rx_pop, tmo_hit, push, bypass;
  logic              mis_n, orph_n, ovf_n, match_n;
  logic [ADD_W-1:0]  tmo_num, err_add;
  logic [SUM_W-1:0]  err_sum;

  // Out-of-range channels never compare equal to any c below, so they are
  // silently ignored.
  assign tx_beat = enable && tx_valid && tx_ready;
  assign rx_beat = enable && rx_valid && rx_ready;

  always_comb begin
    tx_hit  = '0;
    rx_hit  = '0;
    rx_pop  = '0;
    tmo_hit = '0;
    push    = '0;
    bypass  = '0;
    mis_n   = 1'b0;
    orph_n  = 1'b0;
    ovf_n   = 1'b0;
    match_n = 1'b0;
    tmo_num = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      tx_hit[c] = tx_beat && (tx_chan == CH_W'(c));
      rx_hit[c] = rx_beat && (rx_chan == CH_W'(c));
      rx_pop[c] = rx_hit[c] && (occ[c] != '0);
      bypass[c] = rx_hit[c] && (occ[c] == '0) && tx_hit[c];
      // A same-cycle RX pop wins over the timeout drop of the head.
      tmo_hit[c] = (TIMEOUT != 0) && enable && (occ[c] != '0) &&
                   (age[c] == AGE_W'(TIMEOUT)) && !rx_hit[c];
      // A full FIFO still accepts the push when RX frees a slot this edge.
      push[c] = tx_hit[c] && !bypass[c] &&
                ((occ[c] != OCC_W'(DEPTH)) || rx_pop[c]);
      if (rx_pop[c]) begin
        if (mem[c][rd_ptr[c]] == rx_data) match_n = 1'b1;
        else                              mis_n   = 1'b1;
      end
      if (bypass[c]) begin
        if (tx_data == rx_data) match_n = 1'b1;
        else                    mis_n   = 1'b1;
      end
      if (rx_hit[c] && (occ[c] == '0) && !tx_hit[c]) orph_n = 1'b1;
      if (tx_hit[c] && (occ[c] == OCC_W'(DEPTH)) && !rx_pop[c]) ovf_n = 1'b1;
      tmo_num = tmo_num + ADD_W'(tmo_hit[c]);
    end
  end

  assign err_add = ADD_W'(mis_n) + ADD_W'(orph_n) + ADD_W'(ovf_n) + tmo_num;
  assign err_sum = SUM_W'(err_cnt_o) + SUM_W'(err_add);

  // Payload storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push[c]) mem[c][wr_ptr[c]] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        rd_ptr[c] <= '0;
        wr_ptr[c] <= '0;
        occ[c]    <= '0;
        age[c]    <= '0;
      end
      err_mismatch_o <= 1'b0;
      err_orphan_o   <= 1'b0;
      err_overflow_o <= 1'b0;
      err_timeout_o  <= 1'b0;
      match_cnt_o    <= '0;
      err_cnt_o      <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
        if (rx_pop[c] || tmo_hit[c]) rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
        occ[c] <= occ[c] + OCC_W'(push[c]) - OCC_W'(rx_pop[c] || tmo_hit[c]);
        if (enable) begin
          // Age restarts whenever the head changes or nothing is queued.
          if (rx_pop[c] || tmo_hit[c] || (occ[c] == '0)) age[c] <= '0;
          else                                           age[c] <= age[c] + AGE_W'(1);
        end
      end
      err_mismatch_o <= mis_n;
      err_orphan_o   <= orph_n;
      err_overflow_o <= ovf_n;
      err_timeout_o  <= (tmo_hit != '0);
      if (match_n && (match_cnt_o != CNT_MAX)) match_cnt_o <= match_cnt_o + CNT_W'(1);
      if (err_sum > SUM_W'(CNT_MAX)) err_cnt_o <= CNT_MAX;
      else                           err_cnt_o <= err_sum[CNT_W-1:0];
    end
  end

  always_comb begin
    pending_o = '0;
    for (int c = 0; c < NUM_CH; c++) pending_o[c] = (occ[c] != '0);
  end
  assign idle_o = (pending_o == '0);

`ifdef UVME_ST_CHKR_SVA_EN
  a_tx_hold: assert property (@(posedge clk) disable iff (reset)
    tx_valid && !tx_ready |=> tx_valid && $stable(tx_chan) && $stable(tx_data))
    else $error("tx valid/chan/data not held while stalled");
  a_rx_hold: assert property (@(posedge clk) disable iff (reset)
    rx_valid && !rx_ready |=> rx_valid && $stable(rx_chan) && $stable(rx_data))
    else $error("rx valid/chan/data not held while stalled");
  a_tx_chan: assert property (@(posedge clk) disable iff (reset)
    tx_valid |-> (int'(tx_chan) < NUM_CH))
    else $error("tx_chan out of range");
  a_rx_chan: assert property (@(posedge clk) disable iff (reset)
    rx_valid |-> (int'(rx_chan) < NUM_CH))
    else $error("rx_chan out of range");
  a_valid_known: assert property (@(posedge clk) disable iff (reset)
    !$isunknown(tx_valid) && !$isunknown(rx_valid))
    else $error("unknown value on tx_valid/rx_valid");
  a_no_mismatch: assert property (@(posedge clk) disable iff (reset) !err_mismatch_o)
    else $error("stream checker: data mismatch");
  a_no_orphan: assert property (@(posedge clk) disable iff (reset) !err_orphan_o)
    else $error("stream checker: orphan rx beat");
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !err_overflow_o)
    else $error("stream checker: expected fifo overflow");
  a_no_timeout: assert property (@(posedge clk) disable iff (reset) !err_timeout_o)
    else $error("stream checker: head latency timeout");
`endif

endmodule

// File: tb/tb_uvme_st_stream_chkr.sv
// ---------------------------------------------------------------------------
// tb_uvme_st_stream_chkr
//   Directed scenarios followed by a randomized phase. A queue-per-channel
//   reference model predicts flags, counters, pending and idle after every
//   clock edge.
// ---------------------------------------------------------------------------
module tb_uvme_st_stream_chkr;

  localparam int DW   = 32;
  localparam int NC   = 4;
  localparam int DP   = 4;
  localparam int TO   = 16;
  localparam int CW   = 4;
  localparam int CH_W = 2;
  localparam int CMAX = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          enable = 1'b0;
  logic          tx_valid = 1'b0, tx_ready = 1'b0;
  logic [CH_W-1:0] tx_chan = '0;
  logic [DW-1:0] tx_data = '0;
  logic          rx_valid = 1'b0, rx_ready = 1'b0;
  logic [CH_W-1:0] rx_chan = '0;
  logic [DW-1:0] rx_data = '0;
  logic          err_mismatch_o, err_orphan_o, err_overflow_o, err_timeout_o;
  logic [CW-1:0] match_cnt_o, err_cnt_o;
  logic [NC-1:0] pending_o;
  logic          idle_o;

  uvme_st_stream_chkr #(
    .DATA_W(DW), .NUM_CH(NC), .DEPTH(DP), .TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_chan(tx_chan), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_chan(rx_chan), .rx_data(rx_data),
    .err_mismatch_o(err_mismatch_o), .err_orphan_o(err_orphan_o),
    .err_overflow_o(err_overflow_o), .err_timeout_o(err_timeout_o),
    .match_cnt_o(match_cnt_o), .err_cnt_o(err_cnt_o),
    .pending_o(pending_o), .idle_o(idle_o)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q [NC][$];
  int   m_age [NC];
  int   m_match = 0;
  int   m_err = 0;
  logic [3:0] m_flags = '0;   // {mismatch, orphan, overflow, timeout}

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      exp_q[c].delete();
      m_age[c] = 0;
    end
    m_match = 0;
    m_err   = 0;
    m_flags = '0;
  endtask

  // One enabled/disabled clock edge worth of the checker's rules.
  task automatic model_edge(input bit en, input bit tv, input bit tr, input int tc,
                            input logic [DW-1:0] td, input bit rv, input bit rr,
                            input int rc, input logic [DW-1:0] rd);
    bit txb, rxb, byp, mis, orph, ovf;
    int ntmo, nmatch;
    bit was_empty [NC];
    bit popped [NC];
    bit tmo [NC];
    logic [DW-1:0] head;
    byp = 0; mis = 0; orph = 0; ovf = 0; ntmo = 0; nmatch = 0;
    m_flags = '0;
    if (!en) return;
    txb = tv && tr && (tc < NC);
    rxb = rv && rr && (rc < NC);
    for (int c = 0; c < NC; c++) begin
      was_empty[c] = (exp_q[c].size() == 0);
      popped[c] = 0;
      tmo[c] = (TO != 0) && !was_empty[c] && (m_age[c] == TO) && !(rxb && rc == c);
    end
    if (rxb) begin
      if (exp_q[rc].size() > 0) begin
        head = exp_q[rc].pop_front();
        popped[rc] = 1;
        if (head == rd) nmatch = 1; else mis = 1;
      end else if (txb && tc == rc) begin
        byp = 1;
        if (td == rd) nmatch = 1; else mis = 1;
      end else begin
        orph = 1;
      end
    end
    if (txb && !byp) begin
      if (exp_q[tc].size() < DP) exp_q[tc].push_back(td);
      else ovf = 1;
    end
    for (int c = 0; c < NC; c++) begin
      if (tmo[c]) begin
        void'(exp_q[c].pop_front());
        popped[c] = 1;
        ntmo++;
      end
      m_age[c] = (popped[c] || was_empty[c]) ? 0 : m_age[c] + 1;
    end
    m_match = (m_match + nmatch > CMAX) ? CMAX : m_match + nmatch;
    m_err   = (m_err + mis + orph + ovf + ntmo > CMAX) ? CMAX : m_err + mis + orph + ovf + ntmo;
    m_flags = {mis, orph, ovf, (ntmo > 0)};
  endtask

  task automatic check_outputs(input string tag);
    logic [NC-1:0] pend;
    pend = '0;
    for (int c = 0; c < NC; c++) pend[c] = (exp_q[c].size() > 0);
    check({tag, "_flags"}, 64'({err_mismatch_o, err_orphan_o, err_overflow_o, err_timeout_o}),
          64'(m_flags));
    check({tag, "_match"}, 64'(match_cnt_o), 64'(m_match));
    check({tag, "_err"},   64'(err_cnt_o),   64'(m_err));
    check({tag, "_pend"},  64'(pending_o),   64'(pend));
    check({tag, "_idle"},  64'(idle_o),      64'(pend == '0));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit en, input bit tv, input bit tr, input int tc,
                      input logic [DW-1:0] td, input bit rv, input bit rr,
                      input int rc, input logic [DW-1:0] rd, input string tag);
    @(negedge clk);
    enable   = en;
    tx_valid = tv; tx_ready = tr; tx_chan = CH_W'(tc); tx_data = td;
    rx_valid = rv; rx_ready = rr; rx_chan = CH_W'(rc); rx_data = rd;
    model_edge(en, tv, tr, tc, td, rv, rr, rc, rd);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic tx_only(input int c, input logic [DW-1:0] d, input string tag);
    step(1, 1, 1, c, d, 0, 1, 0, '0, tag);
  endtask

  task automatic rx_only(input int c, input logic [DW-1:0] d, input string tag);
    step(1, 0, 1, 0, '0, 1, 1, c, d, tag);
  endtask

  task automatic idle_step(input string tag);
    step(1, 0, 0, 0, '0, 0, 0, 0, '0, tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    enable = 1'b1;
    tx_valid = 1'b0; rx_valid = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_outputs(tag);
    check({tag, "_idle_one"}, 64'(idle_o), 64'(1));
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    do_reset("rst");

    // In-order matches on one channel
    tx_only(0, 32'hA5, "inord");
    tx_only(0, 32'h5A, "inord");
    rx_only(0, 32'hA5, "inord");
    rx_only(0, 32'h5A, "inord");
    check("inord_match2", 64'(match_cnt_o), 64'(2));
    check("inord_idle",   64'(idle_o), 64'(1));

    // Mismatch
    tx_only(2, 32'h11, "mis");
    rx_only(2, 32'h22, "mis");
    check("mis_pulse", 64'(err_mismatch_o), 64'(1));
    idle_step("mis_after");
    check("mis_one_cycle", 64'(err_mismatch_o), 64'(0));

    // Overflow then drain
    do_reset("rst2");
    for (int i = 0; i < 5; i++) tx_only(0, DW'(32'h100 + i), "ovf");
    check("ovf_pulse", 64'(err_overflow_o), 64'(1));
    for (int i = 0; i < 4; i++) rx_only(0, DW'(32'h100 + i), "drain");
    check("drain_match4", 64'(match_cnt_o), 64'(4));

    // Bypass into empty FIFO
    step(1, 1, 1, 1, 32'h33, 1, 1, 1, 32'h33, "byp");
    check("byp_pend1", 64'(pending_o[1]), 64'(0));

    // Full FIFO plus same-edge TX/RX: no overflow
    for (int i = 0; i < 4; i++) tx_only(1, DW'(i + 1), "fill");
    step(1, 1, 1, 1, 32'd5, 1, 1, 1, 32'd1, "fullsame");
    check("fullsame_noovf", 64'(err_overflow_o), 64'(0));
    for (int i = 2; i <= 5; i++) rx_only(1, DW'(i), "fulldrain");

    // Enable low: beats ignored, content retained
    tx_only(0, 32'h77, "en");
    step(0, 1, 1, 0, 32'h88, 1, 1, 0, 32'h77, "en_off");
    check("en_off_pend", 64'(pending_o[0]), 64'(1));
    rx_only(0, 32'h77, "en_on");

    // Head timeout, then orphan
    do_reset("rst3");
    tx_only(3, 32'h99, "tmo");
    for (int i = 0; i < TO; i++) idle_step("tmo_wait");
    check("tmo_not_yet", 64'(err_timeout_o), 64'(0));
    idle_step("tmo_edge");
    check("tmo_pulse", 64'(err_timeout_o), 64'(1));
    check("tmo_pend3", 64'(pending_o[3]), 64'(0));
    rx_only(3, 32'h99, "orph");
    check("orph_pulse", 64'(err_orphan_o), 64'(1));

    // Randomized traffic
    do_reset("rst4");
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) != 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
           $urandom_range(0, NC - 1), DW'($urandom_range(1, 3)),
           1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
           $urandom_range(0, NC - 1), DW'($urandom_range(1, 3)),
           "rand");
    end

    // Reset with entries pending
    do_reset("rst5");
    tx_only(0, 32'h1, "pre");
    tx_only(1, 32'h2, "pre");
    tx_only(2, 32'h3, "pre");
    do_reset("rst_mid");
    check("rst_mid_cnt", 64'({match_cnt_o, err_cnt_o}), 64'(0));
    check("rst_mid_flags", 64'({err_mismatch_o, err_orphan_o, err_overflow_o, err_timeout_o}),
          64'(0));
    idle_step("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
